// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: registered 1-to-N valid/ready stream demux with one-entry
// output register per channel and a saturating counter of illegal-select drops.
module demux_stream_1xn #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [7:0]           drop_cnt
);
  logic [N-1:0]        vld_q;
  logic [WIDTH-1:0]    dat_q [N];
  logic [2**SEL_W-1:0] busy;
  logic                legal;
  logic                acc;
  // busy is padded to the full select range so illegal selects read as not busy
  always_comb begin
    busy = '0;
    busy[N-1:0] = vld_q & ~out_ready;
  end
  assign legal    = {1'b0, in_sel} < (SEL_W+1)'(N);
  assign in_ready = !busy[in_sel];
  assign acc      = in_valid & in_ready;
  assign out_valid = vld_q;
  for (genvar g = 0; g < N; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = dat_q[g];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < N; i++) dat_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (acc && in_sel == SEL_W'(i)) begin
          vld_q[i] <= 1'b1;
          dat_q[i] <= in_data;
        end else if (out_ready[i]) begin
          vld_q[i] <= 1'b0;
        end
      end
      if (acc && !legal && !(&drop_cnt)) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_demux_stream_1xn.sv
// tb_demux_stream_1xn: table vectors, hand sequences and a random run against
// a slot-level model for N=4, plus an N=3 instance for illegal-select drops.
module tb_demux_stream_1xn;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid, out_ready;
  logic [7:0]  drop_cnt;
  logic [7:0]  b_data;
  logic [1:0]  b_sel;
  logic        b_valid, b_ready;
  logic [23:0] b_out_data;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [7:0]  b_drop;
  demux_stream_1xn #(.N(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt));
  demux_stream_1xn #(.N(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
    .in_ready(b_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .drop_cnt(b_drop));
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
  endtask
  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_vld;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl [10];
  bit         mv [4];
  logic [7:0] md [4];
  initial begin
    rst = 1'b1;
    drive(1'b1, 2'd0, 8'hAA, 4'h0);
    b_valid = 1'b1; b_sel = 2'd0; b_data = 8'h99; b_out_ready = 3'b000;
    // reset with a beat offered: nothing may be captured
    repeat (2) step();
    chk("rst_vld", out_valid, 4'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_drop", drop_cnt, 8'h0);
    chk("rst_b_vld", b_out_valid, 3'h0);
    chk("rst_b_drop", b_drop, 8'h0);
    rst = 1'b0; in_valid = 1'b0; b_valid = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    step();
    chk("idle_vld", out_valid, 4'h0);
    chk("idle_data", out_data, 32'h0);
    // round-robin then back-pressure isolation on channel 2
    tbl[0] = '{1'b1, 2'd0, 8'h10, 4'hF, 1'b1, 4'b0001, 32'h00000010};
    tbl[1] = '{1'b1, 2'd1, 8'h11, 4'hF, 1'b1, 4'b0010, 32'h00001110};
    tbl[2] = '{1'b1, 2'd2, 8'h12, 4'hF, 1'b1, 4'b0100, 32'h00121110};
    tbl[3] = '{1'b1, 2'd3, 8'h13, 4'hF, 1'b1, 4'b1000, 32'h13121110};
    tbl[4] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h13121110};
    tbl[5] = '{1'b1, 2'd2, 8'hA0, 4'hB, 1'b1, 4'b0100, 32'h13A01110};
    tbl[6] = '{1'b1, 2'd2, 8'hB0, 4'hB, 1'b0, 4'b0100, 32'h13A01110};
    tbl[7] = '{1'b1, 2'd2, 8'hB0, 4'hF, 1'b1, 4'b0100, 32'h13B01110};
    tbl[8] = '{1'b1, 2'd1, 8'hC0, 4'hF, 1'b1, 4'b0010, 32'h13B0C010};
    tbl[9] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h13B0C010};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
      step();
      chk($sformatf("tbl%0d_vld", i), out_valid, tbl[i].exp_vld);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
    end
    // back-to-back drain and refill of channel 0
    drive(1'b1, 2'd0, 8'h50, 4'hF);
    step();
    for (int k = 1; k <= 8; k++) begin
      in_data = 8'(8'h50 + k);
      #1;
      chk("refill_in_ready", in_ready, 1'b1);
      step();
      chk("refill_vld", out_valid, 4'b0001);
      chk("refill_data", out_data[7:0], 8'(8'h50 + k));
    end
    in_valid = 1'b0;
    step();
    chk("refill_empty", out_valid, 4'h0);
    // fill all channels while stalled, then reset mid-stream
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 2'(c), 8'(8'h21 + c), 4'h0);
      step();
    end
    chk("fill_vld", out_valid, 4'hF);
    chk("fill_data", out_data, 32'h24232221);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_vld", out_valid, 4'h0);
    chk("midrst_data", out_data, 32'h0);
    chk("midrst_drop", drop_cnt, 8'h0);
    // illegal select on the N=3 instance: drop counter saturates
    b_out_ready = 3'b111; b_valid = 1'b1; b_sel = 2'd3; b_data = 8'h5A;
    for (int i = 0; i < 260; i++) begin
      #1;
      chk("ill_in_ready", b_ready, 1'b1);
      step();
      chk("ill_vld", b_out_valid, 3'b000);
      chk("ill_drop", b_drop, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
    end
    b_sel = 2'd1; b_data = 8'h77;
    #1;
    chk("legal_in_ready", b_ready, 1'b1);
    step();
    chk("legal_vld", b_out_valid, 3'b010);
    chk("legal_data", b_out_data[15:8], 8'h77);
    chk("legal_drop", b_drop, 8'd255);
    b_valid = 1'b0;
    step();
    chk("legal_drained", b_out_valid, 3'b000);
    // random traffic against the slot model
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin mv[c] = 1'b0; md[c] = 8'h0; end
    for (int n = 0; n < 400; n++) begin
      logic r, exp_rdy;
      r = ($urandom_range(0, 49) == 0);
      rst = r;
      drive(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
      exp_rdy = !(mv[in_sel] && !out_ready[in_sel]);
      #1;
      chk("rnd_in_ready", in_ready, exp_rdy);
      step();
      if (r) begin
        for (int c = 0; c < 4; c++) begin mv[c] = 1'b0; md[c] = 8'h0; end
      end else begin
        for (int c = 0; c < 4; c++) if (mv[c] && out_ready[c]) mv[c] = 1'b0;
        if (in_valid && exp_rdy) begin mv[in_sel] = 1'b1; md[in_sel] = in_data; end
      end
      chk("rnd_vld", out_valid, {mv[3], mv[2], mv[1], mv[0]});
      chk("rnd_data", out_data, {md[3], md[2], md[1], md[0]});
      chk("rnd_drop", drop_cnt, 8'h0);
    end
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
